// File: rtl/fib_pkg.sv
// Shared types and constants for the 64-bit Fibonacci sequence generator.
// The optional term trace (FIB_TERM_TRACE_EN) is configured in fib_sequencer.
package fib_pkg;

    localparam int FIB_WIDTH = 64;
    // F(93) is the largest Fibonacci number that fits in 64 unsigned bits.
    localparam int FIB_MAX_N = 93;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } fib_state_t;

    typedef logic [FIB_WIDTH-1:0] fib_word_t;

endpackage

// File: rtl/fib_datapath.sv
// Fibonacci iteration registers: a holds F(k), b holds F(k+1).
// Provides load and step controls, and flags when k has reached the requested index.
module fib_datapath #(
    parameter int WIDTH   = 64,
    parameter int N_WIDTH = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [N_WIDTH-1:0] n_load,
    output logic [WIDTH-1:0]   a,
    output logic               last
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [N_WIDTH-1:0] k_q, k_d;
    logic [N_WIDTH-1:0] n_q, n_d;

    // Next-state logic. Load takes priority over step. b may wrap on the last
    // step before MAX_N; that wrapped value is never returned.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        k_d = k_q;
        n_d = n_q;
        if (load) begin
            n_d = n_load;
            a_d = '0;
            b_d = WIDTH'(1);
            k_d = '0;
        end else if (step) begin
            a_d = b_q;
            b_d = a_q + b_q;
            k_d = k_q + N_WIDTH'(1);
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            k_q <= '0;
            n_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            k_q <= k_d;
            n_q <= n_d;
        end
    end

    assign a    = a_q;
    assign last = (k_q == n_q);

endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci engine: accepts an index n, iterates one term per cycle, and returns F(n).
// Request and response both use valid/ready handshakes.
// Optional macro FIB_TERM_TRACE_EN adds a term_valid/term_data stream of F(0)..F(n).
//
// state   | meaning
// IDLE    | waiting for a request, start_ready high
// COMPUTE | stepping a/b once per cycle until k == n
// DONE    | result_valid high, holding result until the consumer accepts it
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int WIDTH   = FIB_WIDTH,
    parameter int N_WIDTH = 7,
    parameter int MAX_N   = FIB_MAX_N
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [N_WIDTH-1:0] n_in,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [WIDTH-1:0]   result,
    output logic               overflow,
`ifdef FIB_TERM_TRACE_EN
    output logic               term_valid,
    output logic [WIDTH-1:0]   term_data,
`endif
    output logic               busy
);

    localparam logic [N_WIDTH-1:0] MAX_N_IDX = N_WIDTH'(MAX_N);

    fib_state_t       state_q;
    logic             start_ready_q;
    logic             result_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;
    logic             busy_q;

    logic             accept;
    logic             n_over;
    logic             dp_load;
    logic             dp_step;
    logic [WIDTH-1:0] dp_a;
    logic             dp_last;

    // Datapath control: load on an in-range request, step every non-final COMPUTE cycle.
    always_comb begin
        accept  = (state_q == IDLE) && start_valid;
        n_over  = (n_in > MAX_N_IDX);
        dp_load = accept && !n_over;
        dp_step = (state_q == COMPUTE) && !dp_last;
    end

    fib_datapath #(
        .WIDTH   (WIDTH),
        .N_WIDTH (N_WIDTH)
    ) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .load   (dp_load),
        .step   (dp_step),
        .n_load (n_in),
        .a      (dp_a),
        .last   (dp_last)
    );

    // Sequencing FSM with registered handshake and status outputs.
    // result is deliberately left untouched on the way back to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (n_over) begin
                            state_q        <= DONE;
                            result_valid_q <= 1'b1;
                            result_q       <= '0;
                            overflow_q     <= 1'b1;
                        end else begin
                            state_q <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    if (dp_last) begin
                        state_q        <= DONE;
                        result_valid_q <= 1'b1;
                        result_q       <= dp_a;
                        overflow_q     <= 1'b0;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_q        <= IDLE;
                        result_valid_q <= 1'b0;
                        start_ready_q  <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    start_ready_q  <= 1'b1;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;

`ifdef FIB_TERM_TRACE_EN
    // a holds F(k) throughout COMPUTE, so each COMPUTE cycle emits exactly one term.
    assign term_valid = (state_q == COMPUTE) && !reset;
    assign term_data  = dp_a;
`endif

endmodule
